// File: rtl/exec_alu_stage.sv
// Execute stage: single-cycle ALU ops plus a 32-iteration shift-add multiply,
// with results presented through a one-entry valid/ready output register.
module exec_alu_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] read1,
  input  logic [DATA_W-1:0] read2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_outValid;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;

  logic              w_accept;
  logic [DATA_W-1:0] w_aluResult;
  logic [DATA_W-1:0] w_mulSum;
  logic              w_loadResult;
  logic [DATA_W-1:0] w_loadValue;
  logic              w_startMul;
  logic              w_mulStep;
  logic              w_sltBit;

  assign in_ready  = (r_state == IDLE) && (!r_outValid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_outValid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign busy      = (r_state == MUL);

  assign w_sltBit = ($signed(read1) < $signed(read2));
  assign w_mulSum = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_aluResult = '0;
    case (op)
      OP_ADD: w_aluResult = read1 + read2;
      OP_SUB: w_aluResult = read1 - read2;
      OP_AND: w_aluResult = read1 & read2;
      OP_OR:  w_aluResult = read1 | read2;
      OP_XOR: w_aluResult = read1 ^ read2;
      OP_SLT: w_aluResult = {{(DATA_W-1){1'b0}}, w_sltBit};
      OP_SLL: w_aluResult = read1 << read2[CNT_W-1:0];
      OP_MUL: w_aluResult = '0;
      default: w_aluResult = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The last multiply step folds its partial product straight into the result register.
  always_comb begin
    w_nextState  = r_state;
    w_loadResult = 1'b0;
    w_loadValue  = w_aluResult;
    w_startMul   = 1'b0;
    w_mulStep    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (op == OP_MUL) begin
            w_startMul  = 1'b1;
            w_nextState = MUL;
          end else begin
            w_loadResult = 1'b1;
          end
        end
      end
      MUL: begin
        w_mulStep = 1'b1;
        if (r_cnt == '1) begin
          w_loadResult = 1'b1;
          w_loadValue  = w_mulSum;
          w_nextState  = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_startMul) begin
      r_mcand  <= read1;
      r_mplier <= read2;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_mulStep) begin
      r_acc    <= w_mulSum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // A multiply start only happens when the old result is gone or leaving this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
    end else if (w_loadResult) begin
      r_outValid <= 1'b1;
      r_result   <= w_loadValue;
      r_zero     <= (w_loadValue == '0);
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_alu_stage.sv
// Directed bench for exec_alu_stage: a cycle-level reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_exec_alu_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [2:0]  opCode = 3'b000;
  logic [31:0] opA = 32'h0;
  logic [31:0] opB = 32'h0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [31:0] resultOut;
  logic        zeroOut;
  logic        busyOut;

  int nChecks = 0;
  int nFail   = 0;

  logic        checkEn = 1'b0;
  logic        mValid  = 1'b0;
  logic [31:0] mResult = 32'h0;
  logic        mZero   = 1'b0;
  logic        mBusy   = 1'b0;
  logic [31:0] mProd   = 32'h0;
  int          mLeft   = 0;

  exec_alu_stage #(.DATA_W(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .op        (opCode),
    .read1     (opA),
    .read2     (opB),
    .out_valid (outValid),
    .out_ready (outReady),
    .result    (resultOut),
    .zero      (zeroOut),
    .busy      (busyOut)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] opc, input logic [31:0] a,
                               input logic [31:0] b, input logic ready);
    inValid  = valid;
    opCode   = opc;
    opA      = a;
    opB      = b;
    outReady = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] aluModel(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
    case (opc)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return a * b;
    endcase
  endfunction

  // Reference model: a multiply simply delivers the full product 32 edges after accept.
  always @(posedge clk) begin
    logic accept;
    checkEn = 1'b1;
    if (rst) begin
      mValid = 1'b0; mResult = 32'h0; mZero = 1'b0; mBusy = 1'b0; mLeft = 0;
    end else begin
      accept = inValid && !mBusy && (!mValid || outReady);
      if (mBusy) begin
        mLeft--;
        if (mLeft == 0) begin
          mBusy = 1'b0; mValid = 1'b1; mResult = mProd; mZero = (mProd == 32'h0);
        end
      end else begin
        if (mValid && outReady) mValid = 1'b0;
        if (accept) begin
          if (opCode == 3'd7) begin
            mBusy = 1'b1; mLeft = 32; mProd = opA * opB;
          end else begin
            mResult = aluModel(opCode, opA, opB);
            mZero   = (mResult == 32'h0);
            mValid  = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model out_valid", {31'b0, outValid}, {31'b0, mValid});
      checkOutput("model result",    resultOut,         mResult);
      checkOutput("model zero",      {31'b0, zeroOut},  {31'b0, mZero});
      checkOutput("model busy",      {31'b0, busyOut},  {31'b0, mBusy});
      checkOutput("model in_ready",  {31'b0, inReady},
                  {31'b0, !mBusy && (!mValid || outReady)});
    end
  end

  typedef struct {
    logic [2:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  initial begin
    vec_t table1 [6];
    table1[0] = '{3'd2, 32'hF0F0_1234, 32'h0FF0_FF00};
    table1[1] = '{3'd3, 32'h0000_00F0, 32'h0000_0F00};
    table1[2] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0001};
    table1[3] = '{3'd5, 32'h0000_0005, 32'hFFFF_FFFD};
    table1[4] = '{3'd1, 32'h1234_5678, 32'h1234_5678};
    table1[5] = '{3'd6, 32'h8000_0001, 32'h0000_001F};

    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset out_valid", {31'b0, outValid}, 32'h0);
    checkOutput("reset result",    resultOut,         32'h0);

    applyStimulus(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h1, 1'b1);
    tick();
    checkOutput("add wrap result", resultOut,         32'h0);
    checkOutput("add wrap zero",   {31'b0, zeroOut},  32'h1);
    checkOutput("add out_valid",   {31'b0, outValid}, 32'h1);

    applyStimulus(1'b1, 3'd1, 32'd5, 32'd7, 1'b1);
    tick();
    checkOutput("sub result", resultOut, 32'hFFFF_FFFE);
    checkOutput("sub in_ready", {31'b0, inReady}, 32'h1);
    applyStimulus(1'b1, 3'd5, 32'h8000_0000, 32'h1, 1'b1);
    tick();
    checkOutput("slt result", resultOut, 32'h1);
    applyStimulus(1'b1, 3'd6, 32'h1, 32'h0000_0025, 1'b1);
    tick();
    checkOutput("sll result", resultOut, 32'h20);
    checkOutput("sll zero",   {31'b0, zeroOut}, 32'h0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, table1[i].opc, table1[i].a, table1[i].b, 1'b1);
      tick();
    end
    checkOutput("table sll31 result", resultOut, 32'h8000_0000);

    applyStimulus(1'b1, 3'd7, 32'h0001_0003, 32'h0002_0005, 1'b1);
    tick();
    applyStimulus(1'b1, 3'd0, 32'h1, 32'h1, 1'b1);
    for (int i = 0; i < 32; i++) begin
      checkOutput("mul busy",      {31'b0, busyOut},  32'h1);
      checkOutput("mul in_ready",  {31'b0, inReady},  32'h0);
      checkOutput("mul out_valid", {31'b0, outValid}, 32'h0);
      tick();
    end
    checkOutput("mul result",    resultOut,         32'h000B_000F);
    checkOutput("mul out_valid", {31'b0, outValid}, 32'h1);
    checkOutput("mul busy done", {31'b0, busyOut},  32'h0);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    tick();

    applyStimulus(1'b1, 3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
    tick();
    checkOutput("xor result", resultOut, 32'h0FF0_0FF0);
    applyStimulus(1'b1, 3'd0, 32'h1, 32'h1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp result",    resultOut,         32'h0FF0_0FF0);
      checkOutput("bp in_ready",  {31'b0, inReady},  32'h0);
      checkOutput("bp out_valid", {31'b0, outValid}, 32'h1);
      tick();
    end
    applyStimulus(1'b1, 3'd0, 32'h1, 32'h1, 1'b1);
    #1;
    checkOutput("release in_ready", {31'b0, inReady}, 32'h1);
    tick();
    checkOutput("release add result", resultOut, 32'h2);

    applyStimulus(1'b1, 3'd7, 32'd3, 32'd4, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    checkOutput("abort busy",      {31'b0, busyOut},  32'h0);
    checkOutput("abort out_valid", {31'b0, outValid}, 32'h0);
    checkOutput("abort in_ready",  {31'b0, inReady},  32'h1);
    rst = 1'b0;
    applyStimulus(1'b1, 3'd0, 32'd2, 32'd3, 1'b1);
    tick();
    checkOutput("post-abort add",       resultOut,         32'd5);
    checkOutput("post-abort out_valid", {31'b0, outValid}, 32'h1);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 40; i++) tick();
    checkOutput("idle no stray result", {31'b0, outValid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
